// File: rtl/fixed_divider_pkg.sv
// Shared types and the saturation rule for the sequential fixed-point divider.
package fixed_divider_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FINISH, DONE} div_state_t;

  typedef struct packed {
    logic [63:0] value;
    logic        overflow;
  } sat_t;

  // Turns an unsigned magnitude plus a sign into a two's-complement value
  // clamped to a signed field of 'width' bits (width < 64).
  function automatic sat_t sat_signed(input logic [63:0] mag, input logic neg,
                                      input int unsigned width);
    logic [63:0] bound;
    sat_t        r;
    bound      = 64'd1 << (width - 1);
    r.overflow = 1'b0;
    if (!neg && (mag > bound - 64'd1)) begin
      r.value    = bound - 64'd1;
      r.overflow = 1'b1;
    end else if (neg && (mag > bound)) begin
      r.value    = ~bound + 64'd1;
      r.overflow = 1'b1;
    end else begin
      r.value = neg ? (~mag + 64'd1) : mag;
    end
    return r;
  endfunction

endpackage

// File: rtl/fixed_divider_div_step.sv
// One restoring-division step: shift a dividend bit into the remainder and
// subtract the divisor when it fits.
module div_step #(
  parameter int B_WIDTH = 16
) (
  input  logic [B_WIDTH:0]   rem,
  input  logic               dividend_msb,
  input  logic [B_WIDTH-1:0] b_mag,
  output logic [B_WIDTH:0]   rem_next,
  output logic               q_bit
);

  logic [B_WIDTH+1:0] rem_shift;
  logic [B_WIDTH+1:0] b_ext;

  assign rem_shift = {rem, dividend_msb};
  assign b_ext     = {2'b00, b_mag};

  // NOTE: every output is assigned on every path, so no latch can be inferred.
  always_comb begin
    q_bit    = 1'b0;
    rem_next = (B_WIDTH+1)'(rem_shift);
    if (rem_shift >= b_ext) begin
      q_bit    = 1'b1;
      rem_next = (B_WIDTH+1)'(rem_shift - b_ext);
    end
  end

endmodule

// File: rtl/fixed_divider.sv
// Sequential signed fixed-point divider: out = (a <<< IN_SCALE) / b, truncated
// toward zero and saturated, one quotient bit per clock over valid/ready.
module fixed_divider
  import fixed_divider_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int OUT_WIDTH = 32,
  parameter int IN_SCALE  = 16
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int N     = A_WIDTH + IN_SCALE;
  localparam int CNT_W = $clog2(N);

  div_state_t         state, state_next;
  logic [N-1:0]       dvd;
  logic [B_WIDTH-1:0] b_mag;
  logic [B_WIDTH:0]   rem;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic               b_zero;

  logic [A_WIDTH-1:0] a_abs;
  logic [B_WIDTH-1:0] b_abs;
  logic [B_WIDTH:0]   rem_next;
  logic               q_bit;
  sat_t               sat_res;
  logic               unused_sat_hi;

  // Magnitudes are unsigned, so the most negative inputs fit without overflow.
  assign a_abs = a[A_WIDTH-1] ? (~a + A_WIDTH'(1)) : a;
  assign b_abs = b[B_WIDTH-1] ? (~b + B_WIDTH'(1)) : b;

  div_step #(.B_WIDTH(B_WIDTH)) u_step (
    .rem          (rem),
    .dividend_msb (dvd[N-1]),
    .b_mag        (b_mag),
    .rem_next     (rem_next),
    .q_bit        (q_bit)
  );

  // After N steps the dividend register holds the quotient magnitude.
  assign sat_res       = sat_signed(64'(dvd), neg, OUT_WIDTH);
  assign unused_sat_hi = ^sat_res.value[63:OUT_WIDTH];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is asynchronous and clears everything.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = (b == '0) ? FINISH : CALC;
      CALC:    if (cnt == CNT_W'(N - 1)) state_next = FINISH;
      FINISH:  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      dvd         <= '0;
      b_mag       <= '0;
      rem         <= '0;
      cnt         <= '0;
      neg         <= 1'b0;
      b_zero      <= 1'b0;
      out         <= '0;
      out_valid   <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd    <= {a_abs, {IN_SCALE{1'b0}}};
            b_mag  <= b_abs;
            neg    <= a[A_WIDTH-1] ^ b[B_WIDTH-1];
            b_zero <= (b == '0);
            rem    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          rem <= rem_next;
          dvd <= {dvd[N-2:0], q_bit};
          cnt <= cnt + CNT_W'(1);
        end
        FINISH: begin
          out_valid <= 1'b1;
          if (b_zero) begin
            // b's sign bit is 0 here, so neg is just the sign of a.
            out         <= neg ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                               : {1'b0, {(OUT_WIDTH-1){1'b1}}};
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else begin
            out         <= sat_res.value[OUT_WIDTH-1:0];
            div_by_zero <= 1'b0;
            overflow    <= sat_res.overflow;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_divider.sv
// Self-checking bench for fixed_divider: vector table, random vectors against a
// division model, backpressure and mid-operation reset sequences.
module tb_fixed_divider;

  logic        clk = 1'b0;
  logic        arst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        div_by_zero;
  logic        overflow;

  always #5 clk = ~clk;

  fixed_divider #(
    .A_WIDTH(16), .B_WIDTH(16), .OUT_WIDTH(32), .IN_SCALE(16)
  ) dut (
    .clk         (clk),
    .arst        (arst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  typedef struct packed {
    logic [31:0] out;
    logic        dbz;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    exp_t        e;
    int          lat;
  } vec_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   accepts = 0;

  always @(posedge clk) if (!arst && in_valid && in_ready) accepts++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv);
    exp_t    e;
    longint  q;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (bv == 16'd0) begin
      e.dbz = 1'b1;
      e.out = av[15] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      q = (longint'($signed(av)) * 65536) / longint'($signed(bv));
      if (q > 64'sd2147483647) begin
        e.out = 32'h7FFF_FFFF;
        e.ovf = 1'b1;
      end else if (q < -64'sd2147483648) begin
        e.out = 32'h8000_0000;
        e.ovf = 1'b1;
      end else begin
        e.out = q[31:0];
      end
    end
    return e;
  endfunction

  task automatic send(input logic [15:0] av, input logic [15:0] bv, input exp_t e);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(e);
  endtask

  // Called one step after the acceptance edge; counts edges until out_valid.
  task automatic wait_result(input string name, input int exp_lat);
    int   lat = 0;
    logic rdy_seen = 1'b0;
    exp_t e;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (in_ready) rdy_seen = 1'b1;
    end
    if (!out_valid) begin
      check({name, "_timeout"}, out_valid, 1);
    end else if (sb.size() == 0) begin
      check({name, "_sb_empty"}, sb.size(), 1);
    end else begin
      e = sb.pop_front();
      check({name, "_latency"}, lat, exp_lat);
      check({name, "_in_ready_busy"}, rdy_seen, 0);
      check({name, "_out"}, out, e.out);
      check({name, "_dbz"}, div_by_zero, e.dbz);
      check({name, "_ovf"}, overflow, e.ovf);
      if (out_ready) begin
        @(posedge clk); #1;
        check({name, "_valid_drop"}, out_valid, 0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[7];
    logic [31:0] held_out;
    logic        held_dbz;
    logic        held_ovf;
    int          acc0;

    vecs[0] = '{16'd6,      16'd3,      '{32'h0002_0000, 1'b0, 1'b0}, 33};
    vecs[1] = '{16'hFFF9,   16'd2,      '{32'hFFFC_8000, 1'b0, 1'b0}, 33};
    vecs[2] = '{16'hFFFF,   16'd3,      '{32'hFFFF_AAAB, 1'b0, 1'b0}, 33};
    vecs[3] = '{16'd5,      16'd0,      '{32'h7FFF_FFFF, 1'b1, 1'b0}, 1};
    vecs[4] = '{16'hFFFB,   16'd0,      '{32'h8000_0000, 1'b1, 1'b0}, 1};
    vecs[5] = '{16'h8000,   16'hFFFF,   '{32'h7FFF_FFFF, 1'b0, 1'b1}, 33};
    vecs[6] = '{16'h8000,   16'd1,      '{32'h8000_0000, 1'b0, 1'b0}, 33};

    arst      = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_dbz", div_by_zero, 0);
    check("rst_ovf", overflow, 0);
    #22;
    arst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].e);
      wait_result($sformatf("vec%0d", i), vecs[i].lat);
    end

    for (int i = 0; i < 8; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = (i % 2 == 1) ? 16'($urandom_range(1, 7)) : 16'($urandom);
      if (i == 4) rb = 16'd0;
      if (i % 3 == 0) rb = ~rb + 16'd1;
      send(ra, rb, model(ra, rb));
      wait_result($sformatf("rnd%0d", i), (rb == 16'd0) ? 1 : 33);
    end

    // Backpressure: result must hold while out_ready is low, with a new
    // request already waiting on in_valid.
    out_ready = 1'b0;
    send(16'd6, 16'd3, model(16'd6, 16'd3));
    wait_result("bp", 33);
    held_out = out;
    held_dbz = div_by_zero;
    held_ovf = overflow;
    a        = 16'd1;
    b        = 16'd1;
    in_valid = 1'b1;
    acc0     = accepts;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_out", i), out, held_out);
      check($sformatf("bp_hold%0d_valid", i), out_valid, 1);
      check($sformatf("bp_hold%0d_in_ready", i), in_ready, 0);
    end
    check("bp_hold_dbz", div_by_zero, held_dbz);
    check("bp_hold_ovf", overflow, held_ovf);
    check("bp_no_accept", accepts, acc0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_valid_drop", out_valid, 0);
    check("bp_in_ready_back", in_ready, 1);
    check("bp_no_accept_at_handshake", accepts, acc0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(model(16'd1, 16'd1));
    check("bp_second_accept", accepts, acc0 + 1);
    wait_result("bp_next", 33);

    // Reset in the middle of a division abandons it immediately.
    send(16'd6, 16'd3, model(16'd6, 16'd3));
    repeat (10) begin
      @(posedge clk); #1;
    end
    #2;
    arst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out", out, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_ovf", overflow, 0);
    sb.delete();
    #7;
    arst = 1'b0;
    @(posedge clk); #1;
    send(16'd6, 16'd3, '{32'h0002_0000, 1'b0, 1'b0});
    wait_result("post_rst", 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fixed_divider.md
Name: fixed_divider

Overview:
- Sequential signed fixed-point divider; the inverse operation of the datapath's scaled multiplier.
- Computes out = (a <<< IN_SCALE) / b, truncated toward zero, and saturates the result to OUT_WIDTH.
- Uses restoring radix-2 division, one quotient bit per clock, so one small datapath replaces a large combinational divider.
- Sits beside the multiplier in the datapath and exchanges operands and results over valid/ready handshakes.

Parameters:
- A_WIDTH, 16: signed dividend width.
- B_WIDTH, 16: signed divisor width.
- OUT_WIDTH, 32: signed result width; default equals A_WIDTH+B_WIDTH.
- IN_SCALE, 16: left shift applied to the dividend, i.e. the fractional bits restored to the result.
- Derived localparam N = A_WIDTH+IN_SCALE: iteration count and quotient magnitude width.

Ports:
- clk, in, 1: single clock; every register uses its rising edge.
- arst, in, 1: asynchronous active-high reset.
- in_valid, in, 1: operands a/b are valid.
- in_ready, out, 1: divider can accept operands.
- a, in, A_WIDTH: signed dividend.
- b, in, B_WIDTH: signed divisor.
- out_valid, out, 1: result is valid.
- out_ready, in, 1: consumer accepts the result.
- out, out, OUT_WIDTH: signed result, registered.
- div_by_zero, out, 1: result came from b==0.
- overflow, out, 1: result was saturated.

Behaviour:
- Reset (async, arst=1): state=IDLE; out=0, out_valid=0, div_by_zero=0, overflow=0; in_ready=1; all internal registers cleared. Reset mid-operation abandons the division; no partial result is ever presented.
- in_ready = (state==IDLE). It is decoded from the registered state only, with no combinational path from in_valid or out_ready.
- Acceptance edge t0 (in_valid && in_ready):
  - Latch |a| and |b| as unsigned magnitudes and the result sign (a[msb] xor b[msb]).
  - Load the dividend shift register with |a| << IN_SCALE (N bits); clear remainder (B_WIDTH+1 bits) and counter.
  - Next state is CALC, or FINISH if b==0.
- CALC, edges t0+1 .. t0+N:
  - rem' = {rem, dividend msb}; shift the dividend left.
  - If rem' >= |b|: rem = rem'-|b| and shift in quotient bit 1; else rem = rem' and shift in 0.
  - The counter increments each edge; at count N-1 the next state is FINISH.
- FINISH, one edge (t0+N+1 normally, t0+1 for b==0):
  - Normal case: apply the sign to the N-bit quotient magnitude Q.
  - Positive result with Q > 2^(OUT_WIDTH-1)-1: out = max positive, overflow=1.
  - Negative result with Q > 2^(OUT_WIDTH-1): out = min negative, overflow=1.
  - Otherwise out = the signed Q, sign-extended or truncated to OUT_WIDTH (truncation is lossless after the saturation check).
  - b==0: out = max positive if a>=0, else min negative; div_by_zero=1, overflow=0.
  - out_valid=1; state=DONE.
- Latency: out_valid rises N+1 cycles after acceptance (33 with defaults); 1 cycle for b==0.
- DONE:
  - out, div_by_zero and overflow stay stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid=0, state=IDLE. out and flags keep their last values; they are meaningful only while out_valid=1.
  - in_ready returns high the cycle after the output handshake. There is no overlap of a new acceptance with the output handshake.
- Remainder signs and width: the remainder never goes negative (restoring algorithm). B_WIDTH+1 bits hold |b| up to 2^(B_WIDTH-1) plus the shift.
- Magnitude of most-negative inputs: -2^(A_WIDTH-1) and -2^(B_WIDTH-1) are handled via unsigned magnitude registers. No overflow is possible in the magnitude.
- Simulation only (TARGET_SYNTHESIS undefined): at time 0, add 2500 to tbench_top.area and $display the amount with %m.

Decomposition:
- fixed_divider_pkg holds:
  - typedef enum logic [1:0] {IDLE, CALC, FINISH, DONE} div_state_t.
  - Function sat_signed(mag, neg, width-bound) for the saturation rule.
- One combinational sub-module, div_step: inputs rem, dividend msb, |b|; outputs next rem and quotient bit. It is instantiated once and reused every CALC cycle.

Test Plan (defaults):
- a=6, b=3 -> out=0x00020000, flags 0; out_valid exactly 33 cycles after the acceptance edge, in_ready low throughout.
- a=-7, b=2 -> out=0xFFFC8000 (-229376). a=-1, b=3 -> out=-21845 (0xFFFFAAAB), confirming truncation toward zero.
- a=5, b=0 -> out=0x7FFFFFFF, div_by_zero=1, 1-cycle latency. a=-5, b=0 -> out=0x80000000, div_by_zero=1.
- a=-32768, b=-1 -> out=0x7FFFFFFF, overflow=1. a=-32768, b=1 -> out=0x80000000, overflow=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out and flags stable, in_ready=0. Then out_ready=1 -> out_valid drops next edge, in_ready=1 the following cycle. in_valid held high meanwhile -> no second acceptance before IDLE.
- Assert arst at CALC iteration 10 -> out_valid=0, out=0 and in_ready=1 immediately (asynchronously). After release, a=6, b=3 -> 0x00020000 after 33 cycles.
